mem_tile_reader: RTL and testbench

MEM_TILE_READER -- requirements
Module: mem_tile_reader

---
 rtl/mem_pkg.sv | 22 ++
 rtl/tile_skid_fifo.sv | 58 +++++
 rtl/mem_tile_reader.sv | 182 ++++++++++++++++++
 tb/tb_mem_tile_reader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizes, row type, FSM states and length clamp for the tile reader
package mem_pkg;

  localparam int NUM_RAMS = 16;
  localparam int D_WID    = 8;
  localparam int LEN_W    = 5;

  localparam logic [LEN_W-1:0] MAX_LEN = 5'd16;

  typedef logic [NUM_RAMS-1:0][D_WID-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/tile_skid_fifo.sv
// rtl/tile_skid_fifo.sv - two-entry FIFO absorbing read data while the output is stalled
module tile_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_tile_reader.sv
// rtl/mem_tile_reader.sv - strided row reader over a banked memory with a two-row output buffer
// Define MEM_TILE_READER_ZERO_PAD_EN to zero out_data bytes at or beyond out_len.
module mem_tile_reader #(
  parameter int NUM_RAMS = mem_pkg::NUM_RAMS,
  parameter int D_WID    = mem_pkg::D_WID
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_base_addr,
  input  logic [7:0]                cmd_rows,
  input  logic [4:0]                cmd_len,
  input  logic [15:0]               cmd_stride,
  output logic                      interface_en,
  output logic                      interface_rdwr,
  output logic [31:0]               interface_addr,
  output logic [4:0]                interface_control,
  input  logic [NUM_RAMS*D_WID-1:0] bank_dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_RAMS*D_WID-1:0] out_data,
  output logic [4:0]                out_len,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_W = NUM_RAMS * D_WID;
  localparam int ENT_W = ROW_W + 6;

  mem_pkg::state_t state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [7:0]  rows_q, rows_d;
  logic [15:0] stride_q, stride_d;
  logic [7:0]  issue_row_q, issue_row_d;
  logic        pend_q, pend_d;
  logic        pend_last_q, pend_last_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;

  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_count;
  logic [ENT_W-1:0] fifo_din, fifo_dout;
  logic             pop;
  logic [2:0]       occ;
  logic             issue_last;
  logic [ROW_W-1:0] head_data;
  logic [4:0]       head_len;
  logic             head_last;

  assign head_last = fifo_dout[0];
  assign head_len  = fifo_dout[5:1];
  assign head_data = fifo_dout[ENT_W-1:6];

  assign out_valid = !fifo_empty;
  assign out_len   = head_len;
  assign out_last  = out_valid && head_last;
  assign pop       = out_valid && out_ready;

  // Rows in flight plus buffered rows; a row leaving this cycle frees its slot.
  assign occ = {2'b00, pend_q} + {1'b0, fifo_count} - {2'b00, pop};

  assign issue_last   = (issue_row_q == rows_q - 8'd1);
  assign interface_en = (state_q == mem_pkg::ST_ISSUE) && (occ < 3'd2) && (!fifo_full || pop);

  assign interface_rdwr    = 1'b0;
  assign interface_addr    = addr_q;
  assign interface_control = ctrl_q;
  assign cmd_ready         = cmd_ready_q;
  assign busy              = (state_q != mem_pkg::ST_IDLE);
  assign done              = done_q;

  assign fifo_din = {bank_dout, ctrl_q, pend_last_q};

  tile_skid_fifo #(
    .W (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    out_data = head_data;
`ifdef MEM_TILE_READER_ZERO_PAD_EN
    for (int i = 0; i < NUM_RAMS; i++) begin
      if (i >= int'(head_len)) begin
        out_data[i*D_WID +: D_WID] = '0;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ctrl_d      = ctrl_q;
    rows_d      = rows_q;
    stride_d    = stride_q;
    issue_row_d = issue_row_q;
    zero_d      = zero_q;
    pend_d      = interface_en;
    pend_last_d = interface_en && issue_last;
    done_d      = pop && head_last;

    case (state_q)
      mem_pkg::ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_base_addr;
          ctrl_d      = mem_pkg::eff_len(cmd_len);
          rows_d      = cmd_rows;
          stride_d    = cmd_stride;
          issue_row_d = 8'd0;
          // Empty commands still pass through DRAIN so cmd_ready drops for one cycle.
          if (cmd_rows == 8'd0 || cmd_len == 5'd0) begin
            zero_d  = 1'b1;
            done_d  = 1'b1;
            state_d = mem_pkg::ST_DRAIN;
          end else begin
            zero_d  = 1'b0;
            state_d = mem_pkg::ST_ISSUE;
          end
        end
      end
      mem_pkg::ST_ISSUE: begin
        if (interface_en) begin
          issue_row_d = issue_row_q + 8'd1;
          addr_d      = addr_q + {16'h0000, stride_q};
          if (issue_last) begin
            state_d = mem_pkg::ST_DRAIN;
          end
        end
      end
      mem_pkg::ST_DRAIN: begin
        if (zero_q || (pop && head_last)) begin
          state_d = mem_pkg::ST_IDLE;
        end
      end
      default: state_d = mem_pkg::ST_IDLE;
    endcase

    cmd_ready_d = (state_d == mem_pkg::ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= mem_pkg::ST_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= 32'h0;
      ctrl_q      <= 5'd0;
      rows_q      <= 8'd0;
      stride_q    <= 16'h0;
      issue_row_q <= 8'd0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      rows_q      <= rows_d;
      stride_q    <= stride_d;
      issue_row_q <= issue_row_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_tile_reader.sv
// tb/tb_mem_tile_reader.sv - table, random and reset-sequence bench for mem_tile_reader
module tb_mem_tile_reader;

`ifdef MEM_TILE_READER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_base_addr;
  logic [7:0]   cmd_rows;
  logic [4:0]   cmd_len;
  logic [15:0]  cmd_stride;
  logic         interface_en;
  logic         interface_rdwr;
  logic [31:0]  interface_addr;
  logic [4:0]   interface_control;
  logic [127:0] bank_dout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [4:0]   out_len;
  logic         out_last;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  mem_tile_reader dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_base_addr     (cmd_base_addr),
    .cmd_rows          (cmd_rows),
    .cmd_len           (cmd_len),
    .cmd_stride        (cmd_stride),
    .interface_en      (interface_en),
    .interface_rdwr    (interface_rdwr),
    .interface_addr    (interface_addr),
    .interface_control (interface_control),
    .bank_dout         (bank_dout),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_len           (out_len),
    .out_last          (out_last),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [7:0] t;
    t = 8'(a[7:0] * 8'd13);
    return t ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // Banked memory: rotated bytes starting at the request address, one cycle later.
  always @(posedge clk) begin
    if (interface_en) begin
      for (int i = 0; i < 16; i++) bank_dout[i*8 +: 8] <= mbyte(interface_addr + 32'(i));
    end else begin
      bank_dout <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  int         rmode = 0;
  int         tcyc  = 0;
  logic [3:0] ptn   = 4'b1001;

  always @(posedge clk) begin
    #1;
    tcyc++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ptn[tcyc % 4];
      2:       out_ready = 1'($urandom);
      default: out_ready = 1'b0;
    endcase
  end

  logic [31:0]     exp_addr[$];
  mem_pkg::row_t   exp_data[$];
  logic [4:0]      exp_len[$];
  logic            exp_last[$];
  logic [4:0]      exp_ctrl;

  bit            mon_on = 0;
  int            n_reqs, n_beats, n_done;
  logic [31:0]   last_addr_seen;
  bit            prev_stall = 0;
  logic [127:0]  prev_data;
  logic [4:0]    prev_len;

  always @(negedge clk) begin
    if (mon_on) begin
      check("rdwr", interface_rdwr, 1'b0);
      if (interface_en) begin
        n_reqs++;
        last_addr_seen = interface_addr;
        check("req_expected", exp_addr.size() > 0, 1'b1);
        if (exp_addr.size() > 0) begin
          check("addr", interface_addr, exp_addr.pop_front());
          check("ctrl", interface_control, exp_ctrl);
        end
      end
      if (out_valid) begin
        if (prev_stall) begin
          check("hold_data", out_data, prev_data);
          check("hold_len", out_len, prev_len);
        end
        if (out_ready) begin
          n_beats++;
          check("beat_expected", exp_data.size() > 0, 1'b1);
          if (exp_data.size() > 0) begin
            check("data", out_data, exp_data.pop_front());
            check("len", out_len, exp_len.pop_front());
            check("last", out_last, exp_last.pop_front());
          end
        end
      end
      check("outstanding_le2", (n_reqs - n_beats) <= 2, 1'b1);
      if (done) n_done++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_len   = out_len;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic build_model(input logic [31:0] base, input logic [7:0] rows,
                             input logic [4:0] len, input logic [15:0] stride);
    int eff;
    eff = (len > 5'd16) ? 16 : int'(len);
    exp_ctrl = 5'(eff);
    exp_addr.delete(); exp_data.delete(); exp_len.delete(); exp_last.delete();
    if (rows != 0 && len != 0) begin
      for (int r = 0; r < int'(rows); r++) begin
        logic [31:0]   a;
        mem_pkg::row_t d;
        a = base + 32'(r) * {16'h0000, stride};
        for (int i = 0; i < 16; i++) d[i] = (PAD && i >= eff) ? 8'h00 : mbyte(a + 32'(i));
        exp_addr.push_back(a);
        exp_data.push_back(d);
        exp_len.push_back(5'(eff));
        exp_last.push_back(r == int'(rows) - 1);
      end
    end
    n_reqs = 0; n_beats = 0; n_done = 0;
  endtask

  task automatic issue_cmd(input logic [31:0] base, input logic [7:0] rows,
                           input logic [4:0] len, input logic [15:0] stride);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_base_addr = base; cmd_rows = rows; cmd_len = len; cmd_stride = stride;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [7:0] rows, input logic [4:0] len,
                         input logic [15:0] stride, input int mode,
                         output int beats, output int reqs, output logic [31:0] laddr,
                         output int done_k, output int lat, output logic r2);
    int lat_k;
    build_model(base, rows, len, stride);
    rmode  = mode;
    lat_k  = -1;
    done_k = -1;
    r2     = 1'b0;
    issue_cmd(base, rows, len, stride);
    for (int k = 1; k <= 400; k++) begin
      if (k == 1) check("busy_ready_after_accept", {busy, cmd_ready}, 2'b10);
      if (k == 2) r2 = cmd_ready;
      if (out_valid && lat_k < 0) lat_k = k;
      if (done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      @(posedge clk);
      #1;
    end
    check("done_seen", done_k >= 0, 1'b1);
    check("leftover", exp_addr.size() + exp_data.size(), 0);
    check("done_count", n_done, 1);
    beats = n_beats;
    reqs  = n_reqs;
    laddr = last_addr_seen;
    lat   = (lat_k < 0) ? -1 : lat_k - 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {cmd_ready, interface_en, interface_rdwr, busy, done,
                          out_valid, out_last, interface_control, out_len}, '0);
    check({tag, "_addr"}, interface_addr, 32'h0);
    check({tag, "_data"}, out_data, 128'h0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [7:0]  rows;
    logic [4:0]  len;
    logic [15:0] stride;
    int          mode;
    int          exp_beats;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          beats, reqs, done_k, lat, eb;
    logic [31:0] laddr;
    logic        r2;
    logic [31:0] rb;
    logic [7:0]  rr;
    logic [4:0]  rl;
    logic [15:0] rs;

    vecs[0] = '{32'h0000_0010, 8'd4, 5'd16, 16'h0010, 0, 4, 32'h0000_0040};
    vecs[1] = '{32'h0000_0023, 8'd3, 5'd5,  16'h0007, 0, 3, 32'h0000_0031};
    vecs[2] = '{32'h0000_0010, 8'd4, 5'd16, 16'h0010, 1, 4, 32'h0000_0040};
    vecs[3] = '{32'hFFFF_FFF0, 8'd2, 5'd16, 16'h0020, 0, 2, 32'h0000_0010};
    vecs[4] = '{32'h0000_0080, 8'd0, 5'd8,  16'h0004, 0, 0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0100, 8'd2, 5'd20, 16'h0003, 0, 2, 32'h0000_0103};
    vecs[6] = '{32'h0000_0050, 8'd3, 5'd0,  16'h0001, 0, 0, 32'h0000_0000};
    vecs[7] = '{32'h0000_0007, 8'd1, 5'd1,  16'h0000, 1, 1, 32'h0000_0007};
    vecs[8] = '{32'h0000_0200, 8'd5, 5'd31, 16'hFFFF, 2, 5, 32'h0004_01FC};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_base_addr = '0; cmd_rows = '0; cmd_len = '0; cmd_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset0");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", cmd_ready, 1'b1);
    mon_on = 1;

    for (int v = 0; v < 9; v++) begin
      run_cmd(vecs[v].base, vecs[v].rows, vecs[v].len, vecs[v].stride, vecs[v].mode,
              beats, reqs, laddr, done_k, lat, r2);
      check($sformatf("v%0d_beats", v), beats, vecs[v].exp_beats);
      check($sformatf("v%0d_reqs", v), reqs, vecs[v].exp_beats);
      if (vecs[v].exp_beats > 0) begin
        check($sformatf("v%0d_last_addr", v), laddr, vecs[v].exp_last_addr);
        if (vecs[v].mode == 0) begin
          check($sformatf("v%0d_first_valid_lat", v), lat, 2);
          check($sformatf("v%0d_done_cycle", v), done_k, int'(vecs[v].rows) + 3);
        end
      end else begin
        check($sformatf("v%0d_zero_done_cycle", v), done_k, 1);
        check($sformatf("v%0d_zero_ready_back", v), r2, 1'b1);
      end
    end

    for (int n = 0; n < 20; n++) begin
      rb = $urandom;
      rr = 8'($urandom_range(0, 6));
      rl = 5'($urandom_range(0, 31));
      rs = 16'($urandom);
      eb = (rr == 0 || rl == 0) ? 0 : int'(rr);
      run_cmd(rb, rr, rl, rs, 2, beats, reqs, laddr, done_k, lat, r2);
      check($sformatf("rnd%0d_beats", n), beats, eb);
      check($sformatf("rnd%0d_reqs", n), reqs, eb);
    end

    // Reset after two of eight rows have been issued, with the output stalled.
    build_model(32'h0000_1000, 8'd8, 5'd16, 16'h0010);
    rmode = 3;
    issue_cmd(32'h0000_1000, 8'd8, 5'd16, 16'h0010);
    for (int w = 0; w < 20 && n_reqs < 2; w++) begin
      @(negedge clk);
      #1;
    end
    check("rst_two_issued", n_reqs, 2);
    mon_on = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_mid_reset", cmd_ready, 1'b1);
    mon_on = 1;
    run_cmd(32'h0000_0010, 8'd4, 5'd16, 16'h0010, 0, beats, reqs, laddr, done_k, lat, r2);
    check("post_rst_beats", beats, 4);
    check("post_rst_last_addr", laddr, 32'h0000_0040);
    check("post_rst_lat", lat, 2);
    mon_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
